// File: rtl/soc_data_mem_param.sv
// soc_data_mem_param
// Avalon-MM slave data memory with byte enables, optional zero-fill after
// reset and a read path of one or two register stages.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   clken                 clock enable, 0 freezes memory, clear counter and read path
//   chipselect            slave select
//   read, write           request strobes (both high at once is ignored)
//   address               word address
//   byteenable            per-byte write enable
//   writedata             write data
//   readdata              read data, held while readdatavalid is low
//   readdatavalid         one pulse per accepted read
//   waitrequest           request not accepted this cycle
//
// States:
//   ST_CLEAR | zero-filling memory, one word per enabled cycle
//   ST_IDLE  | accepting requests
//   ST_STALL | clken dropped with a read in flight, back to idle on next enabled cycle
module soc_data_mem_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;

  logic accept_rd;
  logic accept_wr;
  logic clear_we;
  logic in_flight;

  // A read is still owed to the master while either register stage holds it.
  assign in_flight = out_valid | s1_valid;

  always_comb begin
    state_next  = state;
    waitrequest = 1'b1;
    case (state)
      ST_CLEAR: begin
        if (clken && (clr_addr == LAST_ADDR)) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!clken && in_flight) state_next = ST_STALL;
        waitrequest = reset | ~clken;
      end
      ST_STALL: begin
        if (clken) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET) state <= ST_CLEAR;
      else                state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign accept_rd = chipselect & ~waitrequest & read & ~write;
  assign accept_wr = chipselect & ~waitrequest & write & ~read;
  assign clear_we  = clken & ~reset & (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_addr <= '0;
    end else if (clear_we) begin
      clr_addr <= clr_addr + 1'b1;
    end
  end

  // Memory is deliberately not reset; only the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_addr] <= '0;
    end else if (accept_wr) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (byteenable[b]) mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

  // Read data is captured at the accept edge, so a later write to the same
  // word cannot disturb a read already in the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clken) begin
      if (READ_LATENCY == 2) begin
        s1_valid  <= accept_rd;
        if (accept_rd) s1_data <= mem[address];
        out_valid <= s1_valid;
        if (s1_valid) out_data <= s1_data;
      end else begin
        out_valid <= accept_rd;
        if (accept_rd) out_data <= mem[address];
      end
    end
  end

  // The output stage is frozen while clken is low; masking the qualifier keeps
  // the pulse to exactly one enabled cycle. Reset discards a pending pulse at once.
  assign readdatavalid = out_valid & clken & ~reset;
  assign readdata      = out_data;

endmodule

// File: tb/tb_soc_data_mem_param.sv
// tb_soc_data_mem_param
// Directed bench: two clearing instances (read latency 1 and 2) and one
// non-clearing instance share one stimulus stream.
module tb_soc_data_mem_param;

  logic        clk;
  logic        reset;
  logic        clken;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [3:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;

  logic [31:0] rd1_data, rd2_data, nc_data;
  logic        rd1_valid, rd2_valid, nc_valid;
  logic        wait1, wait2, wait_nc;

  int checks = 0;
  int passed = 0;
  int n1 = 0;
  int n2 = 0;

  soc_data_mem_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_l1 (
    .clk(clk), .reset(reset), .clken(clken), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .byteenable(byteenable), .writedata(writedata),
    .readdata(rd1_data), .readdatavalid(rd1_valid), .waitrequest(wait1));

  soc_data_mem_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) u_l2 (
    .clk(clk), .reset(reset), .clken(clken), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .byteenable(byteenable), .writedata(writedata),
    .readdata(rd2_data), .readdatavalid(rd2_valid), .waitrequest(wait2));

  soc_data_mem_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)) u_nc (
    .clk(clk), .reset(reset), .clken(clken), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .byteenable(byteenable), .writedata(writedata),
    .readdata(nc_data), .readdatavalid(nc_valid), .waitrequest(wait_nc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rd1_valid) n1++;
    if (rd2_valid) n2++;
  end

  // One cycle: drive inputs after the falling edge, let them settle, then the
  // caller inspects this cycle's outputs before the next rising edge.
  task automatic cyc(input logic rst, input logic ce, input logic cs, input logic r, input logic w,
                     input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    reset = rst; clken = ce; chipselect = cs; read = r; write = w;
    address = a; byteenable = b; writedata = d;
    #1;
  endtask

  task automatic nop();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
  endtask

  task automatic wrt(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a, b, d);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    checks++; if (wait1 !== 1'b1) $display("FAIL reset_wait_l1: got %b want 1", wait1); else passed++;
    checks++; if (wait2 !== 1'b1) $display("FAIL reset_wait_l2: got %b want 1", wait2); else passed++;
    checks++; if (wait_nc !== 1'b1) $display("FAIL reset_wait_nc: got %b want 1", wait_nc); else passed++;
    checks++; if ({rd1_valid, rd1_data} !== 33'h0) $display("FAIL reset_out_l1: got %b/%h want 0/0", rd1_valid, rd1_data); else passed++;
    checks++; if ({rd2_valid, rd2_data} !== 33'h0) $display("FAIL reset_out_l2: got %b/%h want 0/0", rd2_valid, rd2_data); else passed++;
    checks++; if ({nc_valid, nc_data} !== 33'h0) $display("FAIL reset_out_nc: got %b/%h want 0/0", nc_valid, nc_data); else passed++;
  endtask

  task automatic test_clear();
    int n;
    nop();
    checks++; if (wait_nc !== 1'b0) $display("FAIL noclear_ready: got %b want 0", wait_nc); else passed++;
    n = 0;
    while (wait1 === 1'b1 && n < 40) begin
      n++;
      nop();
    end
    checks++; if (n !== 16) $display("FAIL clear_wait_cycles: got %0d want 16", n); else passed++;
    checks++; if (wait2 !== 1'b0) $display("FAIL clear_done_l2: got %b want 0", wait2); else passed++;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) rd(4'(i)); else nop();
      if (i >= 1 && i <= 16) begin
        checks++;
        if ({rd1_valid, rd1_data} !== {1'b1, 32'h0})
          $display("FAIL clear_read_l1[%0d]: got %b/%h want 1/00000000", i - 1, rd1_valid, rd1_data);
        else passed++;
      end
      if (i >= 2) begin
        checks++;
        if ({rd2_valid, rd2_data} !== {1'b1, 32'h0})
          $display("FAIL clear_read_l2[%0d]: got %b/%h want 1/00000000", i - 2, rd2_valid, rd2_data);
        else passed++;
      end
    end
  endtask

  task automatic test_byte_write();
    wrt(4'd5, 4'hF, 32'hAABBCCDD);
    wrt(4'd5, 4'h5, 32'h11223344);
    rd(4'd5);
    nop();
    checks++; if ({rd1_valid, rd1_data} !== {1'b1, 32'hAA22CC44}) $display("FAIL byte_write_l1: got %b/%h want 1/aa22cc44", rd1_valid, rd1_data); else passed++;
    checks++; if (rd2_valid !== 1'b0) $display("FAIL byte_write_l2_early: got %b want 0", rd2_valid); else passed++;
    nop();
    checks++; if ({rd2_valid, rd2_data} !== {1'b1, 32'hAA22CC44}) $display("FAIL byte_write_l2: got %b/%h want 1/aa22cc44", rd2_valid, rd2_data); else passed++;
    checks++; if (rd1_valid !== 1'b0) $display("FAIL byte_write_l1_pulse: got %b want 0", rd1_valid); else passed++;
    nop();
    checks++; if ({rd2_valid, rd2_data} !== {1'b0, 32'hAA22CC44}) $display("FAIL byte_write_hold_l2: got %b/%h want 0/aa22cc44", rd2_valid, rd2_data); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] expd [1:3];
    logic        v1, v2;
    expd[1] = 32'h01010101;
    expd[2] = 32'h02020202;
    expd[3] = 32'h03030303;
    wrt(4'd1, 4'hF, expd[1]);
    wrt(4'd2, 4'hF, expd[2]);
    wrt(4'd3, 4'hF, expd[3]);
    wrt(4'd12, 4'hF, 32'hCAFEF00D);
    for (int i = 0; i < 6; i++) begin
      if (i < 3) rd(4'(i + 1)); else nop();
      v1 = (i >= 1 && i <= 3);
      v2 = (i >= 2 && i <= 4);
      checks++; if (rd1_valid !== v1) $display("FAIL b2b_valid_l1[%0d]: got %b want %b", i, rd1_valid, v1); else passed++;
      checks++; if (rd2_valid !== v2) $display("FAIL b2b_valid_l2[%0d]: got %b want %b", i, rd2_valid, v2); else passed++;
      if (v1) begin
        checks++; if (rd1_data !== expd[i]) $display("FAIL b2b_data_l1[%0d]: got %h want %h", i, rd1_data, expd[i]); else passed++;
      end
      if (v2) begin
        checks++; if (rd2_data !== expd[i - 1]) $display("FAIL b2b_data_l2[%0d]: got %h want %h", i, rd2_data, expd[i - 1]); else passed++;
      end
    end
  endtask

  task automatic test_read_after_write();
    wrt(4'd7, 4'hF, 32'hDEADBEEF);
    rd(4'd7);
    nop();
    checks++; if ({rd1_valid, rd1_data} !== {1'b1, 32'hDEADBEEF}) $display("FAIL raw_l1: got %b/%h want 1/deadbeef", rd1_valid, rd1_data); else passed++;
    nop();
    checks++; if ({rd2_valid, rd2_data} !== {1'b1, 32'hDEADBEEF}) $display("FAIL raw_l2: got %b/%h want 1/deadbeef", rd2_valid, rd2_data); else passed++;
    rd(4'd7);
    wrt(4'd7, 4'hF, 32'h12345678);
    checks++; if ({rd1_valid, rd1_data} !== {1'b1, 32'hDEADBEEF}) $display("FAIL war_l1: got %b/%h want 1/deadbeef", rd1_valid, rd1_data); else passed++;
    nop();
    checks++; if ({rd2_valid, rd2_data} !== {1'b1, 32'hDEADBEEF}) $display("FAIL war_l2: got %b/%h want 1/deadbeef", rd2_valid, rd2_data); else passed++;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'hF, 32'hFFFFFFFF);
    checks++; if (wait1 !== 1'b0) $display("FAIL both_wait: got %b want 0", wait1); else passed++;
    nop();
    checks++; if (rd1_valid !== 1'b0) $display("FAIL both_valid_l1: got %b want 0", rd1_valid); else passed++;
    nop();
    checks++; if (rd2_valid !== 1'b0) $display("FAIL both_valid_l2: got %b want 0", rd2_valid); else passed++;
    rd(4'd7);
    nop();
    checks++; if ({rd1_valid, rd1_data} !== {1'b1, 32'h12345678}) $display("FAIL both_nowrite_l1: got %b/%h want 1/12345678", rd1_valid, rd1_data); else passed++;
    nop();
    checks++; if ({rd2_valid, rd2_data} !== {1'b1, 32'h12345678}) $display("FAIL both_nowrite_l2: got %b/%h want 1/12345678", rd2_valid, rd2_data); else passed++;
  endtask

  task automatic test_clken_stall();
    rd(4'd5);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      checks++; if ({wait1, wait2} !== 2'b11) $display("FAIL stall_wait[%0d]: got %b%b want 11", k, wait1, wait2); else passed++;
      checks++; if ({rd1_valid, rd2_valid} !== 2'b00) $display("FAIL stall_valid[%0d]: got %b%b want 00", k, rd1_valid, rd2_valid); else passed++;
    end
    nop();
    checks++; if ({rd1_valid, rd1_data} !== {1'b1, 32'hAA22CC44}) $display("FAIL stall_resume_l1: got %b/%h want 1/aa22cc44", rd1_valid, rd1_data); else passed++;
    checks++; if (rd2_valid !== 1'b0) $display("FAIL stall_resume_l2_early: got %b want 0", rd2_valid); else passed++;
    nop();
    checks++; if ({rd2_valid, rd2_data} !== {1'b1, 32'hAA22CC44}) $display("FAIL stall_resume_l2: got %b/%h want 1/aa22cc44", rd2_valid, rd2_data); else passed++;
    checks++; if (rd1_valid !== 1'b0) $display("FAIL stall_pulse_l1: got %b want 0", rd1_valid); else passed++;
    checks++; if (wait1 !== 1'b0) $display("FAIL stall_exit_wait: got %b want 0", wait1); else passed++;
  endtask

  task automatic test_reset_mid();
    int p1, p2, n;
    rd(4'd1);
    rd(4'd2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    p1 = n1;
    p2 = n2;
    checks++; if ({rd1_valid, rd2_valid} !== 2'b00) $display("FAIL inflight_reset_valid: got %b%b want 00", rd1_valid, rd2_valid); else passed++;
    nop();
    for (int k = 0; k < 9; k++) nop();
    checks++; if (wait1 !== 1'b1) $display("FAIL midclear_wait: got %b want 1", wait1); else passed++;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    nop();
    n = 0;
    while (wait1 === 1'b1 && n < 40) begin
      n++;
      nop();
    end
    checks++; if (n !== 16) $display("FAIL midclear_restart_cycles: got %0d want 16", n); else passed++;
    checks++; if (n1 !== p1) $display("FAIL inflight_pulses_l1: got %0d want %0d", n1 - p1, 0); else passed++;
    checks++; if (n2 !== p2) $display("FAIL inflight_pulses_l2: got %0d want %0d", n2 - p2, 0); else passed++;
    rd(4'd12);
    rd(4'd5);
    nop();
    checks++; if ({rd1_valid, rd1_data} !== {1'b1, 32'h0}) $display("FAIL reclear_a12_l1: got %b/%h want 1/00000000", rd1_valid, rd1_data); else passed++;
    checks++; if ({rd2_valid, rd2_data} !== {1'b1, 32'h0}) $display("FAIL reclear_a12_l2: got %b/%h want 1/00000000", rd2_valid, rd2_data); else passed++;
    nop();
    checks++; if ({rd2_valid, rd2_data} !== {1'b1, 32'h0}) $display("FAIL reclear_a5_l2: got %b/%h want 1/00000000", rd2_valid, rd2_data); else passed++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = 4'h0; byteenable = 4'h0; writedata = 32'h0;
    test_reset();
    test_clear();
    test_byte_write();
    test_back_to_back();
    test_read_after_write();
    test_clken_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
